// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: register file geometry and the write-back result entry.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ID_W   = 3;
    localparam int NREG   = 2 ** ID_W;

    // One queued result: destination register and the value to write.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO for write-back. Storage is registered and cleared on reset so the
// head reads as zero while empty after reset. Pointers carry one extra wrap bit
// to tell full from empty.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       push_i,
    input  res_entry_t din_i,
    input  logic       pop_i,
    output res_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    res_entry_t  mem_q [DEPTH];

    // Storage writes and pointer advance; the caller only pushes when not full
    // and only pops when not empty.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Head and status flags decoded straight from the registered pointers.
    always_comb begin
        head_o  = mem_q[rd_ptr_q[AW-1:0]];
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back unit: retires queued results to the register file in order and
// keeps a per-register count of outstanding writes for RAW hazard stalls.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_PEND = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Res_Valid,
    output logic              Res_Ready,
    input  logic [ID_W-1:0]   Res_ID,
    input  logic [DATA_W-1:0] Res_Data,
    input  logic              Issue_Valid,
    input  logic [ID_W-1:0]   Issue_ID,
    output logic              Issue_Ready,
    input  logic              Wb_Stall,
    output logic [NREG-1:0]   Busy,
    output logic [ID_W-1:0]   Reg_W_ID,
    output logic              Reg_Write,
    output logic [DATA_W-1:0] Reg_WData,
    output logic              Err
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);

    res_entry_t       push_entry;
    res_entry_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             issue_fire;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             err_q;
    logic             err_d;

    assign push_entry = '{id: Res_ID, data: Res_Data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (Reg_Write),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Handshakes and write port; Res_Ready deliberately ignores the pop so no
    // path exists from Wb_Stall to the upstream ready.
    always_comb begin
        Res_Ready   = !fifo_full;
        push        = Res_Valid && !fifo_full;
        Reg_Write   = !fifo_empty && !Wb_Stall;
        Reg_W_ID    = head.id;
        Reg_WData   = head.data;
        Issue_Ready = (cnt_q[Issue_ID] < CNT_W'(MAX_PEND));
        issue_fire  = Issue_Valid && Issue_Ready;
    end

    // Scoreboard update: a simultaneous issue and retire to one register cancel;
    // a retire against a zero count saturates at zero and flags the error.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue_fire && (Issue_ID == ID_W'(i)) &&
                !(Reg_Write && (Reg_W_ID == ID_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (Reg_Write && (Reg_W_ID == ID_W'(i)) &&
                         !(issue_fire && (Issue_ID == ID_W'(i)))) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
        if (Reg_Write && (cnt_q[Reg_W_ID] == '0)) begin
            err_d = 1'b1;
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Busy flags reflect any outstanding write per register.
    always_comb begin
        Err = err_q;
        for (int i = 0; i < NREG; i++) begin
            Busy[i] = (cnt_q[i] != '0);
        end
    end

endmodule
